vfpu_op_issue: RTL and testbench

- Operand issue queue between the stimulus driver side and the VFPU core. It sits in the dut wrapper path that carries op_vld/operand_a/b/c.
- Accepts instruction plus operand triplets, buffers them in a small FIFO, and issues them to the core with valid/ready handshake.
- Enforces a blocking window after non-pipelined long-latency ops (divide, square root).

---
 rtl/vfpu_op_issue.sv | 118 +++++++++++
 tb/tb_vfpu_op_issue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_op_issue.sv
// vfpu_op_issue: operand issue queue between the op driver and the VFPU core.
// Buffers {ins, a, b, c} in a DEPTH-entry FIFO feeding one output register stage,
// issues with a valid/ready handshake, and holds issue off for BUSY_CYC cycles
// after a divide or square root.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   op_vld, vfpu_ins, operand_*  upstream op; op_rdy high while the FIFO is not full
//   core_vld, core_ins, core_*   issued op; core_rdy is the core's accept
//   fifo_cnt                     FIFO occupancy (output stage not included)
//   ovf_err                      sticky: op offered while op_rdy was low
//   issue_cnt                    wrapping handshake counter, only when
//                                VFPU_ISSUE_CNT_EN is defined, otherwise 0
module vfpu_op_issue #(
    parameter int               DEPTH    = 4,
    parameter int               DW       = 32,
    parameter int               INS_W    = 6,
    parameter logic [INS_W-1:0] DIV_OPC  = 6'd4,
    parameter logic [INS_W-1:0] SQRT_OPC = 6'd5,
    parameter int               BUSY_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_vld,
    input  logic [INS_W-1:0]         vfpu_ins,
    input  logic [DW-1:0]            operand_a,
    input  logic [DW-1:0]            operand_b,
    input  logic [DW-1:0]            operand_c,
    output logic                     op_rdy,
    output logic                     core_vld,
    output logic [INS_W-1:0]         core_ins,
    output logic [DW-1:0]            core_a,
    output logic [DW-1:0]            core_b,
    output logic [DW-1:0]            core_c,
    input  logic                     core_rdy,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     ovf_err,
    output logic [15:0]              issue_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BUSY_CYC + 1);
    localparam int EW = INS_W + 3 * DW;

    typedef enum logic [1:0] {IDLE, VALID, BLOCK} state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [BW-1:0] blk;
    state_t        st, nst;
    logic          push, pop, hs, long_op, nempty;

    assign op_rdy   = cnt != CW'(DEPTH);
    assign fifo_cnt = cnt;
    assign push     = op_vld && op_rdy;
    assign nempty   = cnt != '0;
    assign hs       = core_vld && core_rdy;
    assign long_op  = core_ins == DIV_OPC || core_ins == SQRT_OPC;

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else st <= nst;

    always_comb begin
        nst = st;
        pop = 1'b0;
        case (st)
            IDLE: begin
                nst = nempty ? VALID : IDLE;
                pop = nempty;
            end
            VALID: if (hs) begin
                nst = long_op ? BLOCK : (nempty ? VALID : IDLE);
                pop = !long_op && nempty;
            end
            BLOCK: if (blk == '0) begin
                nst = nempty ? VALID : IDLE;
                pop = nempty;
            end
            default: nst = IDLE;
        endcase
    end

    always_comb core_vld = st == VALID;

    // Storage needs no reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk)
        if (push) mem[wp] <= {vfpu_ins, operand_a, operand_b, operand_c};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            blk     <= '0;
            ovf_err <= 1'b0;
            {core_ins, core_a, core_b, core_c} <= '0;
        end else begin
            wp      <= push ? wp + 1'b1 : wp;
            rp      <= pop ? rp + 1'b1 : rp;
            cnt     <= cnt + CW'(push) - CW'(pop);
            ovf_err <= ovf_err || (op_vld && !op_rdy);
            if (pop) {core_ins, core_a, core_b, core_c} <= mem[rp];
            // Loaded on a long-op issue; reaching zero releases the block on the next edge.
            if (st == VALID && hs && long_op) blk <= BW'(BUSY_CYC - 1);
            else if (st == BLOCK && blk != '0) blk <= blk - 1'b1;
        end

`ifdef VFPU_ISSUE_CNT_EN
    logic [15:0] ic;
    always_ff @(posedge clk or posedge rst)
        if (rst) ic <= '0;
        else if (hs) ic <= ic + 16'd1;
    assign issue_cnt = ic;
`else
    assign issue_cnt = '0;
`endif
endmodule

// File: tb/tb_vfpu_op_issue.sv
// tb_vfpu_op_issue: scoreboard bench for vfpu_op_issue with directed vectors.
module tb_vfpu_op_issue;
    logic        clk = 1'b0, rst = 1'b1, op_vld = 1'b0, core_rdy = 1'b0;
    logic [5:0]  vfpu_ins = '0;
    logic [31:0] operand_a = '0, operand_b = '0, operand_c = '0;
    logic        op_rdy, core_vld, ovf_err;
    logic [5:0]  core_ins;
    logic [31:0] core_a, core_b, core_c;
    logic [2:0]  fifo_cnt;
    logic [15:0] issue_cnt;
    int          total = 0, bad = 0, n_iss = 0;
    logic [101:0] sb[$];
    logic [101:0] exp_e;

    vfpu_op_issue dut (
        .clk(clk), .rst(rst), .op_vld(op_vld), .vfpu_ins(vfpu_ins),
        .operand_a(operand_a), .operand_b(operand_b), .operand_c(operand_c),
        .op_rdy(op_rdy), .core_vld(core_vld), .core_ins(core_ins),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_rdy(core_rdy),
        .fifo_cnt(fifo_cnt), .ovf_err(ovf_err), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && core_vld && core_rdy) begin
            if (sb.size() == 0) chk("unexpected_issue", {core_ins, core_a}, '1);
            else begin
                exp_e = sb.pop_front();
                chk("issue_data", {core_ins, core_a, core_b, core_c}, exp_e);
            end
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] ins, input logic [31:0] a, b, c, input bit acc);
        op_vld = 1'b1;
        vfpu_ins = ins;
        operand_a = a;
        operand_b = b;
        operand_c = c;
        if (acc) begin
            sb.push_back({ins, a, b, c});
            n_iss++;
        end
        tick();
        op_vld = 1'b0;
    endtask

    task automatic drain;
        for (int k = 0; k < 300 && (sb.size() != 0 || core_vld); k++) tick();
        chk("drain_timeout", sb.size(), 0);
    endtask

    function automatic logic [15:0] exp_ic;
`ifdef VFPU_ISSUE_CNT_EN
        return 16'(n_iss);
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", core_vld, 0);
        chk("rst_rdy", op_rdy, 1);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_ic", issue_cnt, 0);
        chk("rst_data", {core_ins, core_a}, 0);
        rst = 1'b0;
        // single op: latency and return to empty
        core_rdy = 1'b1;
        send(6'd0, 32'h3F800000, 32'h40000000, 32'h0, 1);
        chk("t1_cnt_e0", fifo_cnt, 1);
        chk("t1_vld_e0", core_vld, 0);
        tick();
        chk("t1_vld_e1", core_vld, 1);
        chk("t1_a", core_a, 32'h3F800000);
        chk("t1_b", core_b, 32'h40000000);
        chk("t1_cnt_e1", fifo_cnt, 0);
        tick();
        chk("t1_vld_e2", core_vld, 0);
        chk("t1_sb", sb.size(), 0);
        chk("t1_ic", issue_cnt, exp_ic());
        // fill to DEPTH+1, overflow, then back-to-back drain
        core_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send(6'd1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 1);
        chk("t2_rdy_full", op_rdy, 0);
        chk("t2_cnt_full", fifo_cnt, 4);
        chk("t2_ovf_pre", ovf_err, 0);
        send(6'd2, 32'hDEAD, 32'hBEEF, 32'h1, 0);
        chk("t2_ovf", ovf_err, 1);
        chk("t2_cnt_ovf", fifo_cnt, 4);
        core_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_b2b_vld", core_vld, 1);
            tick();
        end
        chk("t2_idle", core_vld, 0);
        chk("t2_sb", sb.size(), 0);
        chk("t2_cnt", fifo_cnt, 0);
        chk("t2_ovf_sticky", ovf_err, 1);
        chk("t2_rdy", op_rdy, 1);
        // long-op blocking window for divide and square root
        for (int o = 4; o <= 5; o++) begin
            send(6'(o), 32'h40400000, 32'h3F000000, 32'h0, 1);
            send(6'd3, 32'h11, 32'h22, 32'h33, 1);
            chk("t3_long_vld", core_vld, 1);
            chk("t3_long_ins", core_ins, o);
            tick();
            for (int i = 0; i < 8; i++) begin
                chk("t3_gap", core_vld, 0);
                tick();
            end
            chk("t3_next_vld", core_vld, 1);
            chk("t3_next_ins", core_ins, 3);
            tick();
            chk("t3_done", core_vld, 0);
        end
        // half full with simultaneous push and issue across pointer wrap
        core_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(6'd1, 32'hA0 + i, 32'hB0 + i, 32'hC0 + i, 1);
        chk("t4_cnt_pre", fifo_cnt, 2);
        core_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(6'(i % 4), 32'h1000 + i, 32'h2000 + i, 32'h3000 + i, 1);
            chk("t4_cnt", fifo_cnt, 2);
        end
        drain();
        chk("t4_cnt_end", fifo_cnt, 0);
        chk("t4_ic", issue_cnt, exp_ic());
        // async reset while blocking with three ops queued
        send(6'd4, 32'h5, 32'h6, 32'h7, 1);
        for (int i = 0; i < 3; i++) send(6'd1, 32'h70 + i, 32'h0, 32'h0, 1);
        chk("t5_cnt_pre", fifo_cnt, 3);
        chk("t5_vld_pre", core_vld, 0);
        #3;
        rst = 1'b1;
        sb.delete();
        n_iss = 0;
        #1;
        chk("t5_vld", core_vld, 0);
        chk("t5_rdy", op_rdy, 1);
        chk("t5_cnt", fifo_cnt, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("t5_no_stale", core_vld, 0);
            tick();
        end
        chk("t5_ovf_clr", ovf_err, 0);
        chk("t5_ic", issue_cnt, 0);
        // async reset drops a presented op at once
        core_rdy = 1'b0;
        send(6'd2, 32'h99, 32'h98, 32'h97, 1);
        tick();
        chk("t5b_vld_pre", core_vld, 1);
        #2;
        rst = 1'b1;
        sb.delete();
        n_iss = 0;
        #1;
        chk("t5b_vld", core_vld, 0);
        chk("t5b_data", core_a, 0);
        tick();
        rst = 1'b0;
        core_rdy = 1'b1;
        // issue counter: wraps when enabled, stays zero otherwise
`ifdef VFPU_ISSUE_CNT_EN
        for (int i = 0; i < 65537; i++) send(6'(i % 4), 32'(i), 32'(i + 1), 32'(i + 2), 1);
        drain();
        chk("t6_wrap", issue_cnt, 16'd1);
`else
        for (int i = 0; i < 3; i++) send(6'd0, 32'(i), 32'(i + 1), 32'(i + 2), 1);
        drain();
        chk("t6_zero", issue_cnt, 16'd0);
`endif
        chk("t6_sb", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
